// File: rtl/wormy_buttons_if.sv
// Button bus for wormy_buttons: raw push-button levels in, accepted direction commands out.
interface wormy_buttons_if;
    logic [3:0] btn_raw;
    logic       button_pushed;
    logic [1:0] button_state;

    modport master (
        output btn_raw,
        input  button_pushed,
        input  button_state
    );

    modport slave (
        input  btn_raw,
        output button_pushed,
        output button_state
    );
endinterface

// File: rtl/wormy_buttons.sv
// Four-button debouncer with press detection and fixed-priority direction encoding.
// Optional macro WORMY_REVERSE_BLOCK_EN drops presses that reverse the last accepted direction.
module wormy_buttons #(
    parameter int DebounceCycles = 1000,
    parameter int CounterWidth   = 16
) (
    input  logic            clk,
    input  logic            rst,
    wormy_buttons_if.slave  bus
);

    localparam logic [CounterWidth-1:0] CntLast = CounterWidth'(DebounceCycles - 1);

    logic [3:0]              sync1;
    logic [3:0]              sync2;
    logic [3:0]              stable;
    logic [3:0]              stable_d;
    logic [3:0]              rise_q;
    logic [CounterWidth-1:0] cnt [4];
    logic                    pushed_q;
    logic [1:0]              state_q;
    logic                    win_valid;
    logic [1:0]              win_dir;
    logic                    accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    // Counter only runs while the synchronized level disagrees with the stable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sync2[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CntLast) begin
                    stable[b] <= ~stable[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= '0;
            rise_q   <= '0;
        end else begin
            stable_d <= stable;
            rise_q   <= stable & ~stable_d;
        end
    end

    always_comb begin
        win_valid = 1'b1;
        win_dir   = 2'b00;
        if (rise_q[0]) begin
            win_dir = 2'b00;
        end else if (rise_q[1]) begin
            win_dir = 2'b01;
        end else if (rise_q[2]) begin
            win_dir = 2'b10;
        end else if (rise_q[3]) begin
            win_dir = 2'b11;
        end else begin
            win_valid = 1'b0;
        end
    end

`ifdef WORMY_REVERSE_BLOCK_EN
    logic [1:0] last_dir;

    assign accept = win_valid && (win_dir != (last_dir ^ 2'b10));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dir <= 2'b00;
        end else if (accept) begin
            last_dir <= win_dir;
        end
    end
`else
    assign accept = win_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pushed_q <= 1'b0;
            state_q  <= 2'b00;
        end else begin
            pushed_q <= accept;
            if (accept) begin
                state_q <= win_dir;
            end
        end
    end

    assign bus.button_pushed = pushed_q;
    assign bus.button_state  = state_q;

endmodule

// File: tb/tb_wormy_buttons.sv
// Randomized and directed bench for wormy_buttons against a sliding-window reference model.
module tb_wormy_buttons;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wormy_buttons_if bus ();

    wormy_buttons #(
        .DebounceCycles (DC),
        .CounterWidth   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = -1;

    // Reference model: raw-sample history window and a two-edge press delay line.
    logic [3:0] m_hist [0:DC+1];
    logic [3:0] m_stable;
    logic [3:0] m_rise_a;
    logic [3:0] m_rise_b;
    logic [1:0] m_last;
    logic       exp_pushed;
    logic [1:0] exp_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic r);
        logic [3:0] tog;
        logic [1:0] dir;
        logic       all_diff;
        logic       ok;
        if (r) begin
            for (int i = 0; i <= DC + 1; i++) m_hist[i] = 4'h0;
            m_stable   = 4'h0;
            m_rise_a   = 4'h0;
            m_rise_b   = 4'h0;
            m_last     = 2'b00;
            exp_pushed = 1'b0;
            exp_state  = 2'b00;
        end else begin
            exp_pushed = 1'b0;
            if (m_rise_b != 4'h0) begin
                dir = 2'd0;
                for (int b = 3; b >= 0; b--) if (m_rise_b[b]) dir = 2'(b);
                ok = 1'b1;
`ifdef WORMY_REVERSE_BLOCK_EN
                if (dir == (m_last ^ 2'b10)) ok = 1'b0;
`endif
                if (ok) begin
                    exp_pushed = 1'b1;
                    exp_state  = dir;
                    m_last     = dir;
                end
            end
            m_rise_b = m_rise_a;
            for (int i = DC + 1; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = raw;
            tog = 4'h0;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int i = 2; i <= DC + 1; i++) if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
                tog[b] = all_diff;
            end
            m_stable = m_stable ^ tog;
            m_rise_a = tog & m_stable;
        end
    endtask

    task automatic step(input logic [3:0] raw, input logic r);
        cyc++;
        bus.btn_raw = raw;
        rst = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        chk("pushed", 32'(bus.button_pushed), 32'(exp_pushed));
        chk("state", 32'(bus.button_state), 32'(exp_state));
        if (bus.button_pushed === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    task automatic do_reset();
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        pulses = 0;
        last_pulse_cyc = -1;
    endtask

    initial begin
        int st;
        logic [3:0] lvl;
        logic [3:0] pat [9];
        bus.btn_raw = 4'h0;

        do_reset();
        chk("reset_pushed", 32'(bus.button_pushed), 32'd0);
        chk("reset_state", 32'(bus.button_state), 32'd0);

        // Up held: one pulse seven edges after first high sample
        st = cyc + 1;
        hold(4'b0001, 20);
        chk("up_pulses", 32'(pulses), 32'd1);
        chk("up_latency", 32'(last_pulse_cyc - st), 32'd7);
        chk("up_state", 32'(bus.button_state), 32'd0);

        // Short glitch on Right is filtered
        do_reset();
        hold(4'b0000, 3);
        hold(4'b0010, 3);
        hold(4'b0000, 12);
        chk("glitch_pulses", 32'(pulses), 32'd0);
        chk("glitch_state", 32'(bus.button_state), 32'd0);

        // Right and Left together: Right wins, Left discarded
        pulses = 0;
        hold(4'b1010, 15);
        chk("prio_pulses", 32'(pulses), 32'd1);
        chk("prio_state", 32'(bus.button_state), 32'd1);

        // Release, then Left: reversal of Right
        hold(4'b0000, 12);
        pulses = 0;
        hold(4'b1000, 15);
`ifdef WORMY_REVERSE_BLOCK_EN
        chk("rev_pulses", 32'(pulses), 32'd0);
        chk("rev_state", 32'(bus.button_state), 32'd1);
`else
        chk("rev_pulses", 32'(pulses), 32'd1);
        chk("rev_state", 32'(bus.button_state), 32'd3);
`endif
        hold(4'b0000, 12);

        // Reset mid-debounce on Down
        do_reset();
        hold(4'b0000, 2);
        hold(4'b0100, 4);
        step(4'b0100, 1'b1);
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        st = cyc + 1;
        hold(4'b0100, 15);
        chk("midrst_pulses", 32'(pulses), 32'd1);
        chk("midrst_latency", 32'(last_pulse_cyc - st), 32'd7);
        chk("midrst_state", 32'(bus.button_state), 32'd2);

        // Bounce on Up before a clean run
        do_reset();
        hold(4'b0000, 2);
        pat = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
        for (int i = 0; i < 9; i++) begin
            if (i == 5) st = cyc + 1;
            step(pat[i], 1'b0);
        end
        hold(4'b0001, 15);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_latency", 32'(last_pulse_cyc - st), 32'd7);

        // Random segments with bounce and occasional reset
        lvl = 4'h0;
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            lvl = lvl ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                logic [3:0] v;
                v = lvl;
                if ($urandom_range(0, 9) == 0) v = v ^ 4'($urandom_range(1, 15));
                step(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
        end
        hold(4'h0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
